// File: rtl/cgra_cfg_pkg.sv
// Shared types for the CGRA configuration loader: the buffered config word,
// the loader state encoding and the idle-bus address.
package cgra_cfg_pkg;

    localparam int CFG_ADDR_W = 32;
    localparam int CFG_DATA_W = 32;

    localparam logic [CFG_ADDR_W-1:0] CFG_IDLE_ADDR = {CFG_ADDR_W{1'b0}};

    typedef struct packed {
        logic [CFG_ADDR_W-1:0] addr;
        logic [CFG_DATA_W-1:0] data;
        logic                  last;
    } cfg_word_t;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2
    } cfg_state_e;

endpackage

// File: rtl/cgra_cfg_fifo.sv
// Show-ahead synchronous FIFO buffering stream words ahead of the config bus.
// Pointers carry one wrap bit so full and empty are distinguishable.
module cgra_cfg_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Flags, guarded push/pop and next pointers.
    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
        do_push  = push && !full;
        do_pop   = pop && !empty;
        rdata    = mem_q[rd_ptr_q[PTR_W-1:0]];
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Pointer registers; reset empties the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= {(PTR_W+1){1'b0}};
            rd_ptr_q <= {(PTR_W+1){1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/cgra_config_loader.sv
// Drains a valid/ready stream of config words onto the CGRA config bus, one
// word per cycle, then waits a settle interval before enabling the fabric.
module cgra_config_loader
    import cgra_cfg_pkg::*;
#(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int FIFO_DEPTH    = 4,
    parameter int SETTLE_CYCLES = 8,
    parameter int CNT_W         = 16
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic              restart,
    output logic [ADDR_W-1:0] config_addr_out,
    output logic [DATA_W-1:0] config_data_out,
    output logic              config_done,
    output logic              run_enable,
    output logic [CNT_W-1:0]  word_count,
    output logic              err_zero_addr
);

    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

    cfg_state_e        state_q, state_d;
    logic              last_seen_q, last_seen_d;
    logic [SET_W-1:0]  settle_q, settle_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              done_q, done_d;
    logic              run_q, run_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              err_q, err_d;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    cfg_word_t         fifo_wdata;
    cfg_word_t         fifo_rdata;

    cgra_cfg_fifo #(
        .WIDTH ($bits(cfg_word_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_in),
        .rst   (reset_in),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Handshake, next-state and next-output logic.
    always_comb begin
        in_ready        = (state_q == ST_LOAD) && !fifo_full && !last_seen_q;
        fifo_push       = in_valid && in_ready;
        fifo_wdata.addr = CFG_ADDR_W'(in_addr);
        fifo_wdata.data = CFG_DATA_W'(in_data);
        fifo_wdata.last = in_last;
        fifo_pop        = 1'b0;
        state_d         = state_q;
        last_seen_d     = last_seen_q || (fifo_push && in_last);
        settle_d        = settle_q;
        addr_d          = {ADDR_W{1'b0}};
        data_d          = {DATA_W{1'b0}};
        done_d          = done_q;
        run_d           = run_q;
        count_d         = count_q;
        err_d           = err_q;
        case (state_q)
            ST_LOAD: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    // A zero address would alias the idle bus, so it is dropped and flagged.
                    if (fifo_rdata.addr == CFG_IDLE_ADDR) begin
                        err_d = 1'b1;
                    end else begin
                        addr_d = ADDR_W'(fifo_rdata.addr);
                        data_d = DATA_W'(fifo_rdata.data);
                        if (count_q != CNT_MAX) begin
                            count_d = count_q + CNT_W'(1);
                        end else begin
                            count_d = count_q;
                        end
                    end
                    if (fifo_rdata.last) begin
                        state_d  = ST_SETTLE;
                        settle_d = SETTLE_LOAD;
                    end else begin
                        state_d  = ST_LOAD;
                    end
                end else begin
                    fifo_pop = 1'b0;
                end
            end
            ST_SETTLE: begin
                if (settle_q == {SET_W{1'b0}}) begin
                    state_d = ST_RUN;
                end else begin
                    settle_d = settle_q - SET_W'(1);
                end
            end
            ST_RUN: begin
                // Enables register one cycle after entry, giving SETTLE_CYCLES idle cycles total.
                if (restart) begin
                    state_d     = ST_LOAD;
                    done_d      = 1'b0;
                    run_d       = 1'b0;
                    last_seen_d = 1'b0;
                    count_d     = {CNT_W{1'b0}};
                    err_d       = 1'b0;
                end else begin
                    done_d = 1'b1;
                    run_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    // State, bus and status registers.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q     <= ST_LOAD;
            last_seen_q <= 1'b0;
            settle_q    <= {SET_W{1'b0}};
            addr_q      <= {ADDR_W{1'b0}};
            data_q      <= {DATA_W{1'b0}};
            done_q      <= 1'b0;
            run_q       <= 1'b0;
            count_q     <= {CNT_W{1'b0}};
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_seen_q <= last_seen_d;
            settle_q    <= settle_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            done_q      <= done_d;
            run_q       <= run_d;
            count_q     <= count_d;
            err_q       <= err_d;
        end
    end

    assign config_addr_out = addr_q;
    assign config_data_out = data_q;
    assign config_done     = done_q;
    assign run_enable      = run_q;
    assign word_count      = count_q;
    assign err_zero_addr   = err_q;

endmodule

// File: tb/tb_cgra_config_loader.sv
// Scoreboard bench for cgra_config_loader: accepted words queue their expected
// bus appearance, a negedge monitor pops and compares whatever the bus shows.
module tb_cgra_config_loader;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int SETTLE = 8;
    localparam int CNT_W  = 16;

    logic              clk_in = 1'b0;
    logic              reset_in;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_addr;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              restart;
    logic [ADDR_W-1:0] config_addr_out;
    logic [DATA_W-1:0] config_data_out;
    logic              config_done;
    logic              run_enable;
    logic [CNT_W-1:0]  word_count;
    logic              err_zero_addr;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        bit          last;
        int          exp_n;
    } exp_t;

    exp_t q[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   ncyc       = 0;
    int   last_n     = 0;

    cgra_config_loader #(
        .ADDR_W        (ADDR_W),
        .DATA_W        (DATA_W),
        .FIFO_DEPTH    (4),
        .SETTLE_CYCLES (SETTLE),
        .CNT_W         (CNT_W)
    ) dut (
        .clk_in          (clk_in),
        .reset_in        (reset_in),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_addr         (in_addr),
        .in_data         (in_data),
        .in_last         (in_last),
        .restart         (restart),
        .config_addr_out (config_addr_out),
        .config_data_out (config_data_out),
        .config_done     (config_done),
        .run_enable      (run_enable),
        .word_count      (word_count),
        .err_zero_addr   (err_zero_addr)
    );

    always #5 clk_in = ~clk_in;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Monitor: every non-idle bus cycle must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_in);
            ncyc++;
            if (!reset_in) begin
                if (config_addr_out != 32'd0) begin
                    if (q.size() == 0) begin
                        chk("unexpected_bus_word", {32'd0, config_addr_out}, 64'd0);
                    end else begin
                        e = q.pop_front();
                        chk("bus_addr", {32'd0, config_addr_out}, {32'd0, e.addr});
                        chk("bus_data", {32'd0, config_data_out}, {32'd0, e.data});
                        chk("bus_latency", 64'(ncyc), 64'(e.exp_n));
                        if (e.last) last_n = ncyc;
                    end
                end else begin
                    chk("idle_data", {32'd0, config_data_out}, 64'd0);
                end
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] d, input bit l);
        exp_t e;
        bit   accepted;
        int   tries;
        accepted = 1'b0;
        tries    = 0;
        @(negedge clk_in);
        in_valid = 1'b1;
        in_addr  = a;
        in_data  = d;
        in_last  = l;
        while (!accepted && tries < 50) begin
            #1;
            if (in_ready) begin
                e.addr  = a;
                e.data  = d;
                e.last  = l;
                e.exp_n = ncyc + 2;
                @(posedge clk_in);
                accepted = 1'b1;
                if (a != 32'd0) q.push_back(e);
            end else begin
                @(negedge clk_in);
                tries++;
            end
        end
        if (!accepted) chk("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic idle();
        @(negedge clk_in);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_run(input string tag, input int exp_cnt, input bit exp_err);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk_in);
            #1;
            if (run_enable) found = 1'b1;
        end
        chk({tag, "_run_reached"}, 64'(found), 64'd1);
        chk({tag, "_settle_gap"}, 64'(ncyc - last_n), 64'(SETTLE + 1));
        chk({tag, "_config_done"}, 64'(config_done), 64'd1);
        chk({tag, "_in_ready_run"}, 64'(in_ready), 64'd0);
        chk({tag, "_word_count"}, 64'(word_count), 64'(exp_cnt));
        chk({tag, "_err_zero"}, 64'(err_zero_addr), 64'(exp_err));
        chk({tag, "_queue_empty"}, 64'(q.size()), 64'd0);
    endtask

    task automatic do_restart(input string tag);
        @(negedge clk_in);
        restart = 1'b1;
        @(negedge clk_in);
        restart = 1'b0;
        #1;
        chk({tag, "_done_clr"}, 64'(config_done), 64'd0);
        chk({tag, "_run_clr"}, 64'(run_enable), 64'd0);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        chk({tag, "_err_clr"}, 64'(err_zero_addr), 64'd0);
        chk({tag, "_count_clr"}, 64'(word_count), 64'd0);
    endtask

    initial begin
        reset_in = 1'b1;
        in_valid = 1'b0;
        in_addr  = 32'd0;
        in_data  = 32'd0;
        in_last  = 1'b0;
        restart  = 1'b0;
        repeat (3) @(negedge clk_in);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_addr", {32'd0, config_addr_out}, 64'd0);
        chk("rst_done_run", {62'd0, config_done, run_enable}, 64'd0);
        chk("rst_count_err", {47'd0, word_count, err_zero_addr}, 64'd0);
        reset_in = 1'b0;

        // Three back-to-back words.
        send(32'h10, 32'hA, 1'b0);
        send(32'h11, 32'hB, 1'b0);
        send(32'h12, 32'hC, 1'b1);
        idle();
        wait_run("b2b", 3, 1'b0);
        do_restart("rs1");

        // Six words streamed while the bus drains.
        for (int i = 0; i < 6; i++) begin
            send(32'h100 + 32'(i), 32'hD00 + 32'(i), (i == 5));
        end
        idle();
        wait_run("six", 6, 1'b0);
        do_restart("rs2");

        // Gapped stream: valid 1,0,0,1.
        send(32'h20, 32'hD, 1'b0);
        idle();
        idle();
        send(32'h21, 32'hE, 1'b1);
        idle();
        wait_run("gap", 2, 1'b0);
        do_restart("rs3");

        // Zero-address word in the middle is dropped and flagged.
        send(32'h5, 32'h1, 1'b0);
        send(32'h0, 32'h2, 1'b0);
        send(32'h6, 32'h3, 1'b1);
        idle();
        wait_run("zero", 2, 1'b1);
        do_restart("rs4");

        // Second bitstream after restart.
        send(32'h30, 32'h1, 1'b0);
        send(32'h31, 32'h2, 1'b1);
        idle();
        wait_run("second", 2, 1'b0);
        do_restart("rs5");

        // Asynchronous reset mid-load discards the partial bitstream.
        send(32'h40, 32'h7, 1'b0);
        send(32'h41, 32'h8, 1'b0);
        send(32'h42, 32'h9, 1'b0);
        #3;
        chk("pre_reset_bus", {32'd0, config_addr_out}, 64'h41);
        reset_in = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("async_reset_addr", {32'd0, config_addr_out}, 64'd0);
        chk("async_reset_data", {32'd0, config_data_out}, 64'd0);
        q.delete();
        repeat (2) @(negedge clk_in);
        reset_in = 1'b0;
        #1;
        chk("post_reset_ready", 64'(in_ready), 64'd1);
        chk("post_reset_count", 64'(word_count), 64'd0);
        send(32'h50, 32'h55, 1'b1);
        idle();
        wait_run("fresh", 1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
